// File: rtl/game_round_sequencer.sv
// Round sequencer in front of Game_State: queues round configs, plays each one
// (clear, INIT pulse, wait for gameover or timeout) and reports the result.
// Optional statistics counters are built when GAME_SEQ_STATS_EN is defined.
module game_round_sequencer #(
  parameter int COUNTER_SIZE   = 4,
  parameter int CFG_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int ROUND_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    run_en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_control,
  input  logic [COUNTER_SIZE-1:0] cfg_value,
  output logic                    game_rst_l,
  output logic [1:0]              control,
  output logic [COUNTER_SIZE-1:0] i_value,
  output logic                    INIT,
  input  logic [1:0]              who,
  input  logic                    gameover,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_who,
  output logic                    res_timeout,
  output logic [ROUND_W-1:0]      res_round,
  output logic                    busy,
  output logic [7:0]              win_total,
  output logic [7:0]              lose_total,
  output logic [7:0]              to_total
);

  localparam int PTR_W = $clog2(CFG_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int ENT_W = 2 + COUNTER_SIZE;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(CFG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_REPORT
  } state_t;

  state_t               state;
  logic [ENT_W-1:0]     mem [CFG_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic [TMR_W-1:0]     timer;
  logic [ROUND_W-1:0]   round_cnt;
  logic                 gameover_q;
  logic                 push;
  logic                 pop;
  logic                 empty;

  // Both ports: a transfer happens on a rising edge where valid && ready; the
  // source holds its payload stable until then, and res_* stay frozen while
  // res_valid waits for res_ready.
  assign cfg_ready = (count != CNT_FULL);
  assign empty     = (count == '0);
  assign push      = cfg_valid && cfg_ready;
  assign pop       = (state == S_CLEAR);
  assign busy      = (state != S_IDLE);
  assign res_round = round_cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cfg_control, cfg_value};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= S_IDLE;
      game_rst_l  <= 1'b1;
      control     <= '0;
      i_value     <= '0;
      INIT        <= 1'b0;
      res_valid   <= 1'b0;
      res_who     <= '0;
      res_timeout <= 1'b0;
      round_cnt   <= '0;
      gameover_q  <= 1'b0;
      timer       <= '0;
    end else begin
      gameover_q <= gameover;
      game_rst_l <= 1'b1;
      INIT       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run_en && !empty) begin
            state      <= S_CLEAR;
            game_rst_l <= 1'b0;
          end
        end
        S_CLEAR: begin
          // Forget any gameover level left from the previous round.
          gameover_q           <= 1'b0;
          timer                <= '0;
          {control, i_value}   <= mem[rd_ptr];
          INIT                 <= 1'b1;
          state                <= S_LOAD;
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          timer <= timer + TMR_W'(1);
          if (gameover && !gameover_q) begin
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_who     <= who;
            res_timeout <= 1'b0;
          end else if (timer == TMR_LAST) begin
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_who     <= 2'b00;
            res_timeout <= 1'b1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            round_cnt <= round_cnt + ROUND_W'(1);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GAME_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      win_total  <= '0;
      lose_total <= '0;
      to_total   <= '0;
    end else if (res_valid && res_ready) begin
      if (res_who == 2'b10 && win_total != 8'hFF)  win_total  <= win_total + 8'd1;
      if (res_who == 2'b01 && lose_total != 8'hFF) lose_total <= lose_total + 8'd1;
      if (res_timeout && to_total != 8'hFF)        to_total   <= to_total + 8'd1;
    end
  end
`else
  assign win_total  = '0;
  assign lose_total = '0;
  assign to_total   = '0;
`endif

endmodule
